// File: rtl/reg_file_wr_arbiter_if.sv
// Bundle of the writeback, external-load, interrupt and reg_file write-port signals.
// The arbiter connects through the slave modport. The requesters and reg_file connect through the master modport.
interface reg_file_wr_arbiter_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5
);
    logic                  WB_VALID;
    logic [ADDR_WIDTH-1:0] WB_ADDR;
    logic [DATA_WIDTH-1:0] WB_DATA;
    logic                  WB_STALL;
    logic                  EXT_VALID;
    logic [ADDR_WIDTH-1:0] EXT_ADDR;
    logic [DATA_WIDTH-1:0] EXT_DATA;
    logic                  EXT_READY;
    logic                  IRQ;
    logic [DATA_WIDTH-1:0] PC_IN;
    logic [DATA_WIDTH-1:0] RAND_IN;
    logic                  ISR_BUSY;
    logic                  ISR_ACK;
    logic [DATA_WIDTH-1:0] RF_IN;
    logic [ADDR_WIDTH-1:0] RF_INADDRESS;
    logic                  RF_WRITE_EN;

    modport master (
        output WB_VALID, WB_ADDR, WB_DATA, EXT_VALID, EXT_ADDR, EXT_DATA,
               IRQ, PC_IN, RAND_IN,
        input  WB_STALL, EXT_READY, ISR_BUSY, ISR_ACK, RF_IN, RF_INADDRESS, RF_WRITE_EN
    );

    modport slave (
        input  WB_VALID, WB_ADDR, WB_DATA, EXT_VALID, EXT_ADDR, EXT_DATA,
               IRQ, PC_IN, RAND_IN,
        output WB_STALL, EXT_READY, ISR_BUSY, ISR_ACK, RF_IN, RF_INADDRESS, RF_WRITE_EN
    );
endinterface

// File: rtl/reg_file_wr_arbiter.sv
// Arbitrates the single reg_file write port among the interrupt context save, external loads
// and pipeline writeback. The reg_file write port is driven only from registers.
module reg_file_wr_arbiter #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned ADDR_WIDTH   = 5,
    parameter int unsigned PC_REG       = 30,
    parameter int unsigned RAND_REG     = 31,
    parameter int unsigned MAX_WAIT     = 4,
    parameter bit          ZERO_PROTECT = 1'b1
) (
    input  logic                 CLK,
    input  logic                 RESET,
    reg_file_wr_arbiter_if.slave bus
);
    localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_SAVE_PC   = 2'd1,
        S_SAVE_RAND = 2'd2,
        S_DONE      = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic                  irq_q, irq_d;
    logic                  pending_q, pending_d;
    logic [WAIT_W-1:0]     wait_cnt_q, wait_cnt_d;
    logic [DATA_WIDTH-1:0] pc_lat_q, pc_lat_d;
    logic [DATA_WIDTH-1:0] rand_lat_q, rand_lat_d;
    logic [DATA_WIDTH-1:0] rf_in_q, rf_in_d;
    logic [ADDR_WIDTH-1:0] rf_addr_q, rf_addr_d;
    logic                  rf_we_q, rf_we_d;
    logic                  isr_busy_q, isr_busy_d;
    logic                  isr_ack_q, isr_ack_d;

    logic                  irq_rise;
    logic                  grant_isr, grant_ext, grant_wb, ext_urgent;
    logic [ADDR_WIDTH-1:0] win_addr;
    logic [DATA_WIDTH-1:0] win_data;

    // Context-save sequencer. An IRQ edge seen while busy is remembered in pending.
    always_comb begin
        state_d    = state_q;
        pending_d  = pending_q;
        pc_lat_d   = pc_lat_q;
        rand_lat_d = rand_lat_q;
        irq_d      = bus.IRQ;
        irq_rise   = bus.IRQ & ~irq_q;
        if ((state_q != S_IDLE) && irq_rise) begin
            pending_d = 1'b1;
        end
        case (state_q)
            S_IDLE: begin
                if (irq_rise || pending_q) begin
                    state_d    = S_SAVE_PC;
                    pc_lat_d   = bus.PC_IN;
                    rand_lat_d = bus.RAND_IN;
                    pending_d  = 1'b0;
                end
            end
            S_SAVE_PC:   state_d = S_SAVE_RAND;
            S_SAVE_RAND: state_d = S_DONE;
            S_DONE:      state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
        isr_busy_d = (state_d != S_IDLE);
        isr_ack_d  = (state_d == S_DONE);
    end

    // Fixed-priority grant: ISR, then a starved EXT, then WB, then EXT.
    always_comb begin
        grant_isr  = (state_q == S_SAVE_PC) || (state_q == S_SAVE_RAND);
        ext_urgent = bus.EXT_VALID && (wait_cnt_q == WAIT_W'(MAX_WAIT));
        grant_ext  = !grant_isr && bus.EXT_VALID && (ext_urgent || !bus.WB_VALID);
        grant_wb   = !grant_isr && !ext_urgent && bus.WB_VALID;

        win_addr = bus.WB_ADDR;
        win_data = bus.WB_DATA;
        if (state_q == S_SAVE_PC) begin
            win_addr = ADDR_WIDTH'(PC_REG);
            win_data = pc_lat_q;
        end else if (state_q == S_SAVE_RAND) begin
            win_addr = ADDR_WIDTH'(RAND_REG);
            win_data = rand_lat_q;
        end else if (grant_ext) begin
            win_addr = bus.EXT_ADDR;
            win_data = bus.EXT_DATA;
        end

        if (!bus.EXT_VALID || grant_ext) begin
            wait_cnt_d = '0;
        end else if (wait_cnt_q != WAIT_W'(MAX_WAIT)) begin
            wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end else begin
            wait_cnt_d = wait_cnt_q;
        end
    end

    // Issue stage: the write port holds its last address and data when no write is issued.
    always_comb begin
        rf_we_d   = (grant_isr || grant_ext || grant_wb) &&
                    !(ZERO_PROTECT && (win_addr == '0));
        rf_in_d   = rf_we_d ? win_data : rf_in_q;
        rf_addr_d = rf_we_d ? win_addr : rf_addr_q;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q    <= S_IDLE;
            irq_q      <= 1'b0;
            pending_q  <= 1'b0;
            wait_cnt_q <= '0;
            pc_lat_q   <= '0;
            rand_lat_q <= '0;
            rf_in_q    <= '0;
            rf_addr_q  <= '0;
            rf_we_q    <= 1'b0;
            isr_busy_q <= 1'b0;
            isr_ack_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            irq_q      <= irq_d;
            pending_q  <= pending_d;
            wait_cnt_q <= wait_cnt_d;
            pc_lat_q   <= pc_lat_d;
            rand_lat_q <= rand_lat_d;
            rf_in_q    <= rf_in_d;
            rf_addr_q  <= rf_addr_d;
            rf_we_q    <= rf_we_d;
            isr_busy_q <= isr_busy_d;
            isr_ack_q  <= isr_ack_d;
        end
    end

    assign bus.WB_STALL     = bus.WB_VALID & ~grant_wb;
    assign bus.EXT_READY    = grant_ext;
    assign bus.ISR_BUSY     = isr_busy_q;
    assign bus.ISR_ACK      = isr_ack_q;
    assign bus.RF_IN        = rf_in_q;
    assign bus.RF_INADDRESS = rf_addr_q;
    assign bus.RF_WRITE_EN  = rf_we_q;
endmodule

// File: tb/tb_reg_file_wr_arbiter.sv
// Directed bench: stimulus pushes the expected reg_file writes, and a negedge monitor pops and compares them.
module tb_reg_file_wr_arbiter;
    logic CLK = 1'b0;
    logic RESET = 1'b1;

    reg_file_wr_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus ();

    reg_file_wr_arbiter #(
        .DATA_WIDTH(32), .ADDR_WIDTH(5), .PC_REG(30), .RAND_REG(31),
        .MAX_WAIT(4), .ZERO_PROTECT(1'b1)
    ) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  n_vec   = 0;
    int  n_err   = 0;
    int  ack_cnt = 0;

    task automatic chk(input string name, input logic [36:0] got, input logic [36:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic push(input logic [4:0] a, input logic [31:0] d);
        wr_t w;
        w.addr = a;
        w.data = d;
        exp_q.push_back(w);
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    // Monitor: every issued write must match the oldest expected write.
    always @(negedge CLK) begin
        if (!RESET) begin
            if (bus.ISR_ACK) ack_cnt++;
            if (bus.RF_WRITE_EN) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", {bus.RF_INADDRESS, bus.RF_IN}, 37'h0);
                end else begin
                    wr_t w;
                    w = exp_q.pop_front();
                    chk("rf_write", {bus.RF_INADDRESS, bus.RF_IN}, {w.addr, w.data});
                end
            end
        end
    end

    initial begin
        bus.WB_VALID = 0; bus.WB_ADDR = 0; bus.WB_DATA = 0;
        bus.EXT_VALID = 0; bus.EXT_ADDR = 0; bus.EXT_DATA = 0;
        bus.IRQ = 0; bus.PC_IN = 0; bus.RAND_IN = 0;

        // Reset state
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_we",    37'(bus.RF_WRITE_EN), 37'd0);
        chk("rst_busy",  37'(bus.ISR_BUSY), 37'd0);
        chk("rst_ack",   37'(bus.ISR_ACK), 37'd0);
        chk("rst_rf",    {bus.RF_INADDRESS, bus.RF_IN}, 37'd0);
        chk("rst_ready", 37'(bus.EXT_READY), 37'd0);
        RESET = 0;
        cyc();

        // Reset asserted mid-SAVE_RAND aborts the save
        bus.IRQ = 1; bus.PC_IN = 32'h11; bus.RAND_IN = 32'h22;
        cyc();
        bus.IRQ = 0; push(5'd30, 32'h11);
        cyc();
        chk("t1_busy_pre", 37'(bus.ISR_BUSY), 37'd1);
        @(negedge CLK);
        #1 RESET = 1;
        #1;
        chk("t1_we",   37'(bus.RF_WRITE_EN), 37'd0);
        chk("t1_busy", 37'(bus.ISR_BUSY), 37'd0);
        cyc();
        RESET = 0;
        cyc();
        cyc();
        chk("t1_idle", 37'(bus.ISR_BUSY), 37'd0);
        chk("t1_noack", 37'(ack_cnt), 37'd0);

        // Uncontended writeback
        bus.WB_VALID = 1; bus.WB_ADDR = 5; bus.WB_DATA = 32'hA5A5_0001;
        #1 chk("t2_stall", 37'(bus.WB_STALL), 37'd0);
        push(5'd5, 32'hA5A5_0001);
        cyc();
        bus.WB_VALID = 0;
        cyc();

        // Interrupt context save while writeback requests keep arriving
        bus.IRQ = 1; bus.PC_IN = 32'h100; bus.RAND_IN = 32'h1234_5678;
        bus.WB_VALID = 1; bus.WB_ADDR = 7; bus.WB_DATA = 32'hD7;
        #1 chk("t3_c0_stall", 37'(bus.WB_STALL), 37'd0);
        push(5'd7, 32'hD7);
        cyc();
        bus.PC_IN = 32'hDEAD_BEEF; bus.RAND_IN = 32'h0;
        bus.WB_ADDR = 8; bus.WB_DATA = 32'hD8;
        #1 chk("t3_c1_stall", 37'(bus.WB_STALL), 37'd1);
        chk("t3_c1_busy", 37'(bus.ISR_BUSY), 37'd1);
        push(5'd30, 32'h100);
        cyc();
        #1 chk("t3_c2_stall", 37'(bus.WB_STALL), 37'd1);
        push(5'd31, 32'h1234_5678);
        cyc();
        #1 chk("t3_c3_stall", 37'(bus.WB_STALL), 37'd0);
        chk("t3_c3_ack", 37'(bus.ISR_ACK), 37'd1);
        push(5'd8, 32'hD8);
        cyc();
        bus.WB_VALID = 0; bus.IRQ = 0;
        #1 chk("t3_c4_ack", 37'(bus.ISR_ACK), 37'd0);
        chk("t3_c4_busy", 37'(bus.ISR_BUSY), 37'd0);
        cyc();
        chk("t3_ackcnt", 37'(ack_cnt), 37'd1);

        // EXT starvation against continuous writeback
        bus.EXT_VALID = 1; bus.EXT_ADDR = 9; bus.EXT_DATA = 32'hE9;
        bus.WB_VALID = 1;
        for (int i = 0; i < 4; i++) begin
            bus.WB_ADDR = 5'(10 + i); bus.WB_DATA = 32'hB000_0000 + 32'(i);
            #1 chk("t4_ready_lo", 37'(bus.EXT_READY), 37'd0);
            chk("t4_wb_go", 37'(bus.WB_STALL), 37'd0);
            push(5'(10 + i), 32'hB000_0000 + 32'(i));
            cyc();
        end
        bus.WB_ADDR = 14; bus.WB_DATA = 32'hB000_0004;
        #1 chk("t4_ready_hi", 37'(bus.EXT_READY), 37'd1);
        chk("t4_wb_stall", 37'(bus.WB_STALL), 37'd1);
        push(5'd9, 32'hE9);
        cyc();
        bus.EXT_VALID = 0;
        #1 chk("t4_wb_resume", 37'(bus.WB_STALL), 37'd0);
        push(5'd14, 32'hB000_0004);
        cyc();
        bus.EXT_VALID = 1; bus.EXT_ADDR = 3; bus.EXT_DATA = 32'hE3;
        bus.WB_ADDR = 15; bus.WB_DATA = 32'hB000_0005;
        #1 chk("t4_cnt_cleared", 37'(bus.EXT_READY), 37'd0);
        push(5'd15, 32'hB000_0005);
        cyc();
        bus.WB_VALID = 0;
        #1 chk("t4_ext_alone", 37'(bus.EXT_READY), 37'd1);
        push(5'd3, 32'hE3);
        cyc();
        bus.EXT_VALID = 0;
        cyc();

        // Write to address 0 is handshaken but not issued
        bus.EXT_VALID = 1; bus.EXT_ADDR = 0; bus.EXT_DATA = 32'hFFFF;
        #1 chk("t5_ready", 37'(bus.EXT_READY), 37'd1);
        cyc();
        bus.EXT_VALID = 0;
        @(negedge CLK);
        #1;
        chk("t5_we", 37'(bus.RF_WRITE_EN), 37'd0);
        chk("t5_hold", {bus.RF_INADDRESS, bus.RF_IN}, {5'd3, 32'hE3});
        cyc();

        // Second IRQ during a save runs a second save after DONE
        bus.IRQ = 1; bus.PC_IN = 32'h200; bus.RAND_IN = 32'hAAAA;
        cyc();
        bus.IRQ = 0; push(5'd30, 32'h200);
        cyc();
        bus.IRQ = 1; bus.PC_IN = 32'h300; bus.RAND_IN = 32'hBBBB;
        push(5'd31, 32'hAAAA);
        cyc();
        bus.IRQ = 0;
        cyc();
        #1 chk("t6_gap_idle", 37'(bus.ISR_BUSY), 37'd0);
        cyc();
        #1 chk("t6_busy2", 37'(bus.ISR_BUSY), 37'd1);
        push(5'd30, 32'h300);
        cyc();
        push(5'd31, 32'hBBBB);
        cyc();
        cyc();
        cyc();
        chk("t6_ackcnt", 37'(ack_cnt), 37'd3);

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge CLK);
        @(negedge CLK);
        #1 chk("drain", 37'(exp_q.size()), 37'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
